// File: rtl/rpn_sequencer.sv
// RPN calculator sequencer: turns keypad tokens into push/pop/swap/write/reset strobes
// for the external operand stack. MUL and DIV are iterative and take one bit per cycle.
module rpn_sequencer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [4:0]       key_code,
  output logic             ready,
  input  logic [WIDTH-1:0] top,
  input  logic [WIDTH-1:0] next,
  input  logic [5:0]       count,
  output logic             stack_push,
  output logic             stack_pop,
  output logic             stack_swap,
  output logic             stack_write,
  output logic             stack_reset,
  output logic [WIDTH-1:0] value,
  output logic [1:0]       status,
  output logic             entry
);

  // state    | meaning
  // IDLE     | ready, waiting for a key
  // ISSUE    | single strobe cycle (or the push of a new digit)
  // PUSHWR   | write of the digit just pushed
  // MULRUN   | shift-add multiply, one bit per cycle
  // DIVRUN   | restoring divide of magnitudes, one bit per cycle
  // DIVFIX   | apply quotient sign
  // WB       | pop+write of the MUL/DIV result
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_PUSHWR, S_MULRUN, S_DIVRUN, S_DIVFIX, S_WB
  } state_t;

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
  localparam logic [5:0]    DEPTH_C  = 6'(DEPTH);

  localparam logic [4:0] K_ENTER = 5'd10;
  localparam logic [4:0] K_ADD   = 5'd11;
  localparam logic [4:0] K_SUB   = 5'd12;
  localparam logic [4:0] K_MUL   = 5'd13;
  localparam logic [4:0] K_DIV   = 5'd14;
  localparam logic [4:0] K_SWAP  = 5'd15;
  localparam logic [4:0] K_DROP  = 5'd16;
  localparam logic [4:0] K_NEG   = 5'd17;
  localparam logic [4:0] K_CLEAR = 5'd18;

  localparam logic [1:0] ST_OK  = 2'd0;
  localparam logic [1:0] ST_UNF = 2'd1;
  localparam logic [1:0] ST_OVF = 2'd2;
  localparam logic [1:0] ST_DZ  = 2'd3;

  state_t           state_q, state_d;
  logic             push_q, push_d, pop_q, pop_d, swap_q, swap_d;
  logic             wr_q, wr_d, rst_q, rst_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [1:0]       status_q, status_d;
  logic             entry_q, entry_d;
  logic             pend_q, pend_d;
  logic [3:0]       dig_q, dig_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             neg_q, neg_d;

  logic             two_ok;
  logic [WIDTH-1:0] mag_top, mag_next, mul_sum;
  logic [WIDTH:0]   rem_sh, rem_diff;
  logic             q_bit;

  assign two_ok   = (count >= 6'd2);
  assign mag_top  = top[WIDTH-1]  ? ('0 - top)  : top;
  assign mag_next = next[WIDTH-1] ? ('0 - next) : next;
  assign mul_sum  = acc_q + (opb_q[0] ? opa_q : '0);
  // Remainder stays below the divisor, so one extra bit is enough for the trial subtract.
  assign rem_sh   = {acc_q, opa_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, opb_q};
  assign q_bit    = ~rem_diff[WIDTH];

  always_comb begin
    state_d  = state_q;
    push_d   = 1'b0;
    pop_d    = 1'b0;
    swap_d   = 1'b0;
    wr_d     = 1'b0;
    rst_d    = 1'b0;
    value_d  = '0;
    status_d = status_q;
    entry_d  = entry_q;
    pend_d   = pend_q;
    dig_d    = dig_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    case (state_q)
      S_IDLE: begin
        if (key_valid) begin
          status_d = ST_OK;
          entry_d  = 1'b0;
          pend_d   = 1'b0;
          if (key_code <= 5'd9) begin
            if (entry_q) begin
              entry_d = 1'b1;
              wr_d    = 1'b1;
              value_d = top * WIDTH'(10) + WIDTH'(key_code[3:0]);
              state_d = S_ISSUE;
            end else if (count == DEPTH_C) begin
              status_d = ST_OVF;
            end else begin
              entry_d = 1'b1;
              push_d  = 1'b1;
              pend_d  = 1'b1;
              dig_d   = key_code[3:0];
              state_d = S_ISSUE;
            end
          end else begin
            case (key_code)
              K_ENTER: ;
              K_ADD, K_SUB: begin
                if (!two_ok) status_d = ST_UNF;
                else begin
                  pop_d   = 1'b1;
                  wr_d    = 1'b1;
                  value_d = (key_code == K_ADD) ? (next + top) : (next - top);
                  state_d = S_ISSUE;
                end
              end
              K_MUL: begin
                if (!two_ok) status_d = ST_UNF;
                else begin
                  acc_d   = '0;
                  opa_d   = next;
                  opb_d   = top;
                  cnt_d   = CNT_INIT;
                  state_d = S_MULRUN;
                end
              end
              K_DIV: begin
                if (!two_ok) status_d = ST_UNF;
                else if (top == '0) begin
                  status_d = ST_DZ;
                  pop_d    = 1'b1;
                  wr_d     = 1'b1;
                  state_d  = S_WB;
                end else begin
                  acc_d   = '0;
                  opa_d   = mag_next;
                  opb_d   = mag_top;
                  neg_d   = next[WIDTH-1] ^ top[WIDTH-1];
                  cnt_d   = CNT_INIT;
                  state_d = S_DIVRUN;
                end
              end
              K_SWAP: begin
                if (!two_ok) status_d = ST_UNF;
                else begin
                  swap_d  = 1'b1;
                  state_d = S_ISSUE;
                end
              end
              K_DROP: begin
                // The bottom element is never removed; it is zeroed instead.
                if (two_ok) pop_d = 1'b1;
                else        wr_d  = 1'b1;
                state_d = S_ISSUE;
              end
              K_NEG: begin
                wr_d    = 1'b1;
                value_d = '0 - top;
                state_d = S_ISSUE;
              end
              K_CLEAR: begin
                rst_d   = 1'b1;
                state_d = S_ISSUE;
              end
              default: ;
            endcase
          end
        end
      end
      S_ISSUE: begin
        if (pend_q) begin
          wr_d    = 1'b1;
          value_d = WIDTH'(dig_q);
          state_d = S_PUSHWR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PUSHWR: state_d = S_IDLE;
      S_MULRUN: begin
        acc_d = mul_sum;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          pop_d   = 1'b1;
          wr_d    = 1'b1;
          value_d = mul_sum;
          state_d = S_WB;
        end
      end
      S_DIVRUN: begin
        // opa shifts the dividend out and the quotient in.
        acc_d = q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        opa_d = {opa_q[WIDTH-2:0], q_bit};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_DIVFIX;
      end
      S_DIVFIX: begin
        pop_d   = 1'b1;
        wr_d    = 1'b1;
        value_d = neg_q ? ('0 - opa_q) : opa_q;
        state_d = S_WB;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
      swap_q   <= 1'b0;
      wr_q     <= 1'b0;
      rst_q    <= 1'b0;
      value_q  <= '0;
      status_q <= ST_OK;
      entry_q  <= 1'b0;
      pend_q   <= 1'b0;
      dig_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      push_q   <= push_d;
      pop_q    <= pop_d;
      swap_q   <= swap_d;
      wr_q     <= wr_d;
      rst_q    <= rst_d;
      value_q  <= value_d;
      status_q <= status_d;
      entry_q  <= entry_d;
      pend_q   <= pend_d;
      dig_q    <= dig_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
    end
  end

  assign ready       = (state_q == S_IDLE);
  assign stack_push  = push_q;
  assign stack_pop   = pop_q;
  assign stack_swap  = swap_q;
  assign stack_write = wr_q;
  assign stack_reset = rst_q;
  assign value       = value_q;
  assign status      = status_q;
  assign entry       = entry_q;

endmodule

// File: doc/rpn_sequencer.md
Name: rpn_sequencer

Overview:
- Initiator for the calculator's 32-entry operand stack: accepts keypad tokens one at a time and drives the stack's push/pop/swap/write/reset controls.
- Reads the stack's top, next and count outputs to perform RPN digit entry and 32-bit integer arithmetic, including iterative multiply and divide.
- Sits between the key decoder and the stack; the display reads the stack's top directly.

Parameters:
- WIDTH, 32, operand width; must match stack word width.
- DEPTH, 32, stack capacity; push is refused when count == DEPTH.

Ports:
- clock  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- key_valid  in  1  token strobe; accepted only on a clock edge where key_valid && ready
- key_code  in  5  token: 0-9 digit, 10 ENTER, 11 ADD, 12 SUB, 13 MUL, 14 DIV, 15 SWAP, 16 DROP, 17 NEG, 18 CLEAR; 19-31 reserved
- ready  out  1  high only in IDLE
- top  in  WIDTH  stack top element
- next  in  WIDTH  stack second element (0 if none)
- count  in  6  stack element count, 1..32
- stack_push  out  1  one-cycle push strobe
- stack_pop  out  1  one-cycle pop strobe
- stack_swap  out  1  one-cycle swap strobe
- stack_write  out  1  one-cycle write strobe; with stack_pop the stack writes the new top
- stack_reset  out  1  one-cycle stack clear strobe
- value  out  WIDTH  write data, valid while stack_write = 1
- status  out  2  0 ok, 1 underflow, 2 overflow, 3 divide-by-zero; set by the last accepted key, cleared on the next acceptance
- entry  out  1  digit-entry mode flag

Behaviour:
- Reset: all strobes 0, value 0, status 0, entry 0, ready 1, state IDLE. Reset mid-MUL/DIV aborts the operation; no writeback occurs.
- States: IDLE, ISSUE, PUSHWR, MULRUN, DIVRUN, DIVFIX, WB.
- All strobes are registered and high for exactly one cycle. ready is 0 from the cycle after acceptance until the cycle after the last strobe.
- Operands (top, next, count) are sampled at the acceptance edge.
- Digit d, entry=1: ISSUE writes top*10+d, wrapping mod 2^32. Latency is 1 strobe cycle.
- Digit d, entry=0:
  - count==DEPTH: status=2, no strobes.
  - Otherwise ISSUE pushes, then PUSHWR writes d. Latency is 2 strobe cycles.
  - entry becomes 1.
- Any non-digit token clears entry to 0.
- ENTER only clears entry; no strobes.
- ADD/SUB: count<2 gives status=1 and no strobes. Otherwise ISSUE asserts pop+write with value = next+top or next-top (wrap).
- MUL: count<2 gives underflow. Otherwise 32 cycles of shift-add in MULRUN on the low 32 bits of next*top, then WB asserts pop+write. Latency is 33 cycles.
- DIV: count<2 gives underflow.
  - top==0: status=3, WB pop+write value 0 (operands consumed).
  - Otherwise signed next/top, truncating toward zero. The magnitude is computed by restoring division in 32 cycles (DIVRUN); DIVFIX applies the sign; WB pops and writes. Latency is 34 cycles.
  - -2^31 / -1 = -2^31 (wrap).
- SWAP: count<2 gives underflow. Otherwise one swap strobe.
- DROP: count>=2 gives pop. count==1 gives write 0 instead (bottom element is never removed).
- NEG: write 0-top (wrap); valid at any count.
- CLEAR: stack_reset strobe; status=0.
- Reserved codes: accepted, no strobes, entry cleared, status=0.
- key_valid while ready=0 is ignored and not queued.
- Strobes are mutually exclusive except pop+write.

Test Plan:
- After reset, keys 1,2,3 (each held until ready) -> push, write 1, write 12, write 123; top=123, count=2, entry=1.
- 7 ENTER 5 SUB -> top=2, count=2. Then 3 ENTER 4 MUL -> ready low 33 cycles; top=12 and next=2, count=3.
- Enter -7, via 7 NEG, then 2 DIV -> top=-3. Then 0 DIV -> status=3, top=0, count decremented.
- Fresh reset, ADD -> status=1, no strobes, count stays 1. DROP at count=1 -> write 0, count 1.
- Push to count=32 via 31 digit/ENTER pairs, then digit 9 -> status=2, no push, count=32.
- Assert reset on cycle 10 of MULRUN -> no writeback, ready=1 next cycle, status=0. key_valid pulsed while busy -> ignored.
